parity_rx_ctrl: RTL and testbench

PARITY_RX_CTRL -- requirements
Module: parity_rx_ctrl

---
 rtl/rx_pkg.sv | 19 +
 rtl/rx_ptr_ctrl.sv | 93 +++++++++
 rtl/parity_rx_ctrl.sv | 170 +++++++++++++++++
 tb/tb_parity_rx_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and helpers for the parity receive controller: FSM state encoding
// and the parity acceptance check.
package rx_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        HOLD = 2'd2,
        FULL = 2'd3
    } rx_state_e;

    localparam int ERR_CNT_W = 8;

    // red_xor is the XOR over {par_bit, word}; even parity wants 0, odd wants 1.
    function automatic logic parity_ok(input logic red_xor, input logic odd);
        return red_xor == odd;
    endfunction

endpackage

// File: rtl/rx_ptr_ctrl.sv
// Destination window pointer: write address, advance/wrap, fill detection,
// sticky wrap flag and saturating accepted-word counter.
module rx_ptr_ctrl #(
    parameter int ADDR_W = 12,
    parameter int WRAP   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic              set_full_i,
    input  logic [ADDR_W-1:0] dst_start_i,
    input  logic [ADDR_W-1:0] dst_end_i,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic              fill_hit_o,
    output logic              full_o,
    output logic              ovf_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_MAX  = {(ADDR_W+1){1'b1}};

    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              last_hit_q, last_hit_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              at_end;

    assign at_end = (wr_addr_q == dst_end_i);

    always_comb begin
        wr_addr_d  = wr_addr_q;
        last_hit_d = last_hit_q;
        full_d     = full_q;
        ovf_d      = ovf_q;
        word_cnt_d = word_cnt_q;
        if (clr_i) begin
            last_hit_d = 1'b0;
            full_d     = 1'b0;
            ovf_d      = 1'b0;
            word_cnt_d = '0;
        end else begin
            if (load_i) begin
                wr_addr_d  = dst_start_i;
                last_hit_d = 1'b0;
            end
            if (adv_i) begin
                // Remember whether this write landed on the last slot; the FSM
                // consults it when the handshake closes.
                last_hit_d = at_end;
                if (word_cnt_q != CNT_MAX) begin
                    word_cnt_d = word_cnt_q + CNT_ONE;
                end
                if (!at_end) begin
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                end else if (WRAP != 0) begin
                    wr_addr_d = dst_start_i;
                    ovf_d     = 1'b1;
                end
            end
            if (set_full_i) begin
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q  <= '0;
            last_hit_q <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            last_hit_q <= last_hit_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign wr_addr_o  = wr_addr_q;
    assign fill_hit_o = last_hit_q && (WRAP == 0);
    assign full_o     = full_q;
    assign ovf_o      = ovf_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: rtl/parity_rx_ctrl.sv
// Parity-checked four-phase word receiver writing into a destination window.
// Define RX_ERRCNT_EN to add the saturating err_cnt parity error counter port.
module parity_rx_ctrl
    import rx_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int WIDTH   = 16,
    parameter int PAR_ODD = 0,
    parameter int WRAP    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [ADDR_W-1:0] dst_start,
    input  logic [ADDR_W-1:0] dst_end,
    input  logic [WIDTH-1:0]  bus_d,
    input  logic              par_bit,
    input  logic              req,
    output logic              ack,
    output logic              nack,
    output logic              full,
    output logic              ovf,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              dst_we,
    output logic [WIDTH-1:0]  dst_din,
    output logic [ADDR_W:0]   word_cnt
`ifdef RX_ERRCNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    rx_state_e         state_q, state_d;
    logic              ack_q, ack_d;
    logic              nack_q, nack_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic [ADDR_W-1:0] wr_addr;
    logic              load, adv, set_full, fill_hit;
    logic              par_good;

    assign par_good = parity_ok(^{par_bit, bus_d}, PAR_ODD != 0);

    always_comb begin
        state_d  = state_q;
        ack_d    = ack_q;
        nack_d   = nack_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        load     = 1'b0;
        adv      = 1'b0;
        set_full = 1'b0;
        if (clr) begin
            state_d = INIT;
            ack_d   = 1'b0;
            nack_d  = 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
                IDLE: begin
                    if (req) begin
                        state_d = HOLD;
                        if (par_good) begin
                            we_d   = 1'b1;
                            addr_d = wr_addr;
                            din_d  = bus_d;
                            ack_d  = 1'b1;
                            adv    = 1'b1;
                        end else begin
                            nack_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!req) begin
                        ack_d  = 1'b0;
                        nack_d = 1'b0;
                        // Only an accepted word can have filled the window.
                        if (ack_q && fill_hit) begin
                            state_d  = FULL;
                            set_full = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                FULL: begin
                    ack_d  = 1'b0;
                    nack_d = 1'b0;
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    rx_ptr_ctrl #(
        .ADDR_W (ADDR_W),
        .WRAP   (WRAP)
    ) u_ptr (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (clr),
        .load_i      (load),
        .adv_i       (adv),
        .set_full_i  (set_full),
        .dst_start_i (dst_start),
        .dst_end_i   (dst_end),
        .wr_addr_o   (wr_addr),
        .fill_hit_o  (fill_hit),
        .full_o      (full),
        .ovf_o       (ovf),
        .word_cnt_o  (word_cnt)
    );

`ifdef RX_ERRCNT_EN
    logic                 err_inc;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign err_inc = !clr && (state_q == IDLE) && req && !par_good;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign ack      = ack_q;
    assign nack     = nack_q;
    assign dst_we   = we_q;
    assign dst_addr = addr_q;
    assign dst_din  = din_q;

endmodule

// File: tb/tb_parity_rx_ctrl.sv
// Randomized self-checking bench: a stopping (WRAP=0) and a wrapping (WRAP=1)
// instance share stimulus and are compared against a window-level reference model.
module tb_parity_rx_ctrl;

    localparam int AW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, clr, req, par_bit;
    logic [AW-1:0] dst_start, dst_end;
    logic [DW-1:0] bus_d;

    logic          ack_w [2];
    logic          nack_w[2];
    logic          full_w[2];
    logic          ovf_w [2];
    logic          we_w  [2];
    logic [AW-1:0] addr_w[2];
    logic [DW-1:0] din_w [2];
    logic [AW:0]   cnt_w [2];
`ifdef RX_ERRCNT_EN
    logic [7:0]    errc_w[2];
`endif

    parity_rx_ctrl #(.ADDR_W(AW), .WIDTH(DW), .PAR_ODD(0), .WRAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .dst_start(dst_start), .dst_end(dst_end),
        .bus_d(bus_d), .par_bit(par_bit), .req(req), .ack(ack_w[0]), .nack(nack_w[0]),
        .full(full_w[0]), .ovf(ovf_w[0]), .dst_addr(addr_w[0]), .dst_we(we_w[0]),
        .dst_din(din_w[0]), .word_cnt(cnt_w[0])
`ifdef RX_ERRCNT_EN
        , .err_cnt(errc_w[0])
`endif
    );

    parity_rx_ctrl #(.ADDR_W(AW), .WIDTH(DW), .PAR_ODD(0), .WRAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .dst_start(dst_start), .dst_end(dst_end),
        .bus_d(bus_d), .par_bit(par_bit), .req(req), .ack(ack_w[1]), .nack(nack_w[1]),
        .full(full_w[1]), .ovf(ovf_w[1]), .dst_addr(addr_w[1]), .dst_we(we_w[1]),
        .dst_din(din_w[1]), .word_cnt(cnt_w[1])
`ifdef RX_ERRCNT_EN
        , .err_cnt(errc_w[1])
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int txn      = 0;

    // Reference model: index 0 stops at the window end, index 1 wraps.
    int ws, wend;
    int ptr_m [2];
    int cnt_m [2];
    int err_m [2];
    bit full_m[2];
    bit ovf_m [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptr_m[d]  = ws;
            cnt_m[d]  = 0;
            err_m[d]  = 0;
            full_m[d] = 1'b0;
            ovf_m[d]  = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s_ack%0d", tag, d),  32'(ack_w[d]),  32'd0);
            check_eq($sformatf("%s_nack%0d", tag, d), 32'(nack_w[d]), 32'd0);
            check_eq($sformatf("%s_full%0d", tag, d), 32'(full_w[d]), 32'd0);
            check_eq($sformatf("%s_ovf%0d", tag, d),  32'(ovf_w[d]),  32'd0);
            check_eq($sformatf("%s_we%0d", tag, d),   32'(we_w[d]),   32'd0);
            check_eq($sformatf("%s_addr%0d", tag, d), 32'(addr_w[d]), 32'd0);
            check_eq($sformatf("%s_din%0d", tag, d),  32'(din_w[d]),  32'd0);
            check_eq($sformatf("%s_cnt%0d", tag, d),  32'(cnt_w[d]),  32'd0);
`ifdef RX_ERRCNT_EN
            check_eq($sformatf("%s_err%0d", tag, d),  32'(errc_w[d]), 32'd0);
`endif
        end
    endtask

    // Expects req already high and the DUTs in IDLE at the coming edge.
    task automatic handshake(input logic [DW-1:0] data, input logic par);
        bit good;
        bit exp_ack[2];
        bit exp_nack[2];
        bit becomes_full[2];
        int exp_addr[2];
        good = ($countones({par, data}) % 2) == 0;
        for (int d = 0; d < 2; d++) begin
            exp_ack[d]      = !full_m[d] && good;
            exp_nack[d]     = !full_m[d] && !good;
            exp_addr[d]     = ptr_m[d];
            becomes_full[d] = 1'b0;
            if (exp_ack[d]) begin
                if (cnt_m[d] < 31) cnt_m[d]++;
                if (ptr_m[d] == wend) begin
                    if (d == 0) becomes_full[d] = 1'b1;
                    else begin
                        ptr_m[d] = ws;
                        ovf_m[d] = 1'b1;
                    end
                end else begin
                    ptr_m[d]++;
                end
            end
            if (exp_nack[d] && err_m[d] < 255) err_m[d]++;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("resp_ack%0d", d),  32'(ack_w[d]),  32'(exp_ack[d]));
            check_eq($sformatf("resp_nack%0d", d), 32'(nack_w[d]), 32'(exp_nack[d]));
            check_eq($sformatf("resp_we%0d", d),   32'(we_w[d]),   32'(exp_ack[d]));
            if (exp_ack[d]) begin
                check_eq($sformatf("wr_addr%0d", d), 32'(addr_w[d]), 32'(exp_addr[d]));
                check_eq($sformatf("wr_din%0d", d),  32'(din_w[d]),  32'(data));
            end
            check_eq($sformatf("resp_cnt%0d", d), 32'(cnt_w[d]), 32'(cnt_m[d]));
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("hold_we%0d", d),   32'(we_w[d]),   32'd0);
            check_eq($sformatf("hold_ack%0d", d),  32'(ack_w[d]),  32'(exp_ack[d]));
            check_eq($sformatf("hold_nack%0d", d), 32'(nack_w[d]), 32'(exp_nack[d]));
        end
        req = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) begin
            if (becomes_full[d]) full_m[d] = 1'b1;
            check_eq($sformatf("rel_ack%0d", d),  32'(ack_w[d]),  32'd0);
            check_eq($sformatf("rel_nack%0d", d), 32'(nack_w[d]), 32'd0);
            check_eq($sformatf("rel_full%0d", d), 32'(full_w[d]), 32'(full_m[d]));
            check_eq($sformatf("rel_ovf%0d", d),  32'(ovf_w[d]),  32'(ovf_m[d]));
            check_eq($sformatf("rel_cnt%0d", d),  32'(cnt_w[d]),  32'(cnt_m[d]));
`ifdef RX_ERRCNT_EN
            check_eq($sformatf("rel_err%0d", d),  32'(errc_w[d]), 32'(err_m[d]));
`endif
        end
        $display("txn %0d: win=%0d..%0d data=%h par=%0b ack=%0b/%0b nack=%0b/%0b cnt=%0d/%0d full=%0b ovf=%0b",
                 txn, ws, wend, data, par, exp_ack[0], exp_ack[1], exp_nack[0], exp_nack[1],
                 cnt_m[0], cnt_m[1], full_m[0], ovf_m[1]);
        txn++;
        tick();
    endtask

    task automatic do_word(input logic [DW-1:0] data, input logic par);
        bus_d   = data;
        par_bit = par;
        req     = 1'b1;
        handshake(data, par);
    endtask

    task automatic restart(input int s, input int e);
        ws        = s;
        wend      = e;
        dst_start = AW'(s);
        dst_end   = AW'(e);
        clr       = 1'b1;
        tick();
        clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("clr_ack%0d", d),  32'(ack_w[d]),  32'd0);
            check_eq($sformatf("clr_full%0d", d), 32'(full_w[d]), 32'd0);
            check_eq($sformatf("clr_ovf%0d", d),  32'(ovf_w[d]),  32'd0);
            check_eq($sformatf("clr_cnt%0d", d),  32'(cnt_w[d]),  32'd0);
        end
        model_reset();
        tick();
    endtask

    initial begin
        logic [DW-1:0] data;
        logic          par;
        int            s, e, n;

        rst_n = 1'b0; clr = 1'b0; req = 1'b0; bus_d = '0; par_bit = 1'b0;
        ws = 2; wend = 4;
        dst_start = AW'(ws); dst_end = AW'(wend);
        #12;
        check_all_zero("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick();

        // Directed window 2..4: good, bad, fill/wrap, then one word past the end.
        do_word(16'h0003, 1'b0);
        do_word(16'h0001, 1'b0);
        do_word(16'h00FF, 1'b0);
        do_word(16'h8001, 1'b1);
        do_word(16'h0007, 1'b1);
        do_word(16'h1234, 1'b1);

        // Restart while in HOLD with req still high across the clr release.
        restart(2, 4);
        bus_d = 16'h0005; par_bit = 1'b0; req = 1'b1;
        tick();
        check_eq("pre_clr_ack0", 32'(ack_w[0]), 32'd1);
        check_eq("pre_clr_ack1", 32'(ack_w[1]), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("hold_clr_ack%0d", d), 32'(ack_w[d]), 32'd0);
            check_eq($sformatf("hold_clr_cnt%0d", d), 32'(cnt_w[d]), 32'd0);
            check_eq($sformatf("hold_clr_we%0d", d),  32'(we_w[d]),  32'd0);
        end
        model_reset();
        tick();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("init_we%0d", d),  32'(we_w[d]),  32'd0);
            check_eq($sformatf("init_ack%0d", d), 32'(ack_w[d]), 32'd0);
        end
        handshake(16'h0005, 1'b0);
        do_word(16'h0006, 1'b0);

        // Asynchronous reset in the middle of a handshake.
        bus_d = 16'h000C; par_bit = 1'b0; req = 1'b1;
        tick();
        #3 rst_n = 1'b0;
        #1 check_all_zero("async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick();
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("post_rst_we%0d", d),  32'(we_w[d]),  32'd0);
            check_eq($sformatf("post_rst_ack%0d", d), 32'(ack_w[d]), 32'd0);
        end
        handshake(16'h000C, 1'b0);

        // Single-slot window.
        restart(7, 7);
        do_word(16'hA5A5, 1'b0);
        do_word(16'h0101, 1'b0);
        do_word(16'h0100, 1'b1);

        // Random windows and words; the last phase is long enough to saturate word_cnt.
        for (int ph = 0; ph < 5; ph++) begin
            s = int'($urandom_range(0, 12));
            e = s + int'($urandom_range(0, 3));
            restart(s, e);
            n = (ph == 4) ? 40 : int'($urandom_range(4, 9));
            for (int i = 0; i < n; i++) begin
                data = DW'($urandom);
                par  = ^data;
                if (ph != 4 && $urandom_range(0, 3) == 0) par = ~par;
                do_word(data, par);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
